wb_commit_unit: RTL
===================

# wb_commit_unit

Write-back commit stage for the five-stage pipelined processor. It consumes the MEM/WB pipeline register outputs, selects the write-back value and commits it to a 32×32 architectural register file. It serves ID-stage reads with same-cycle write bypass and exports the WB forwarding tap for the EX forwarding mux. On a terminate marker it halts commits and streams the final register contents out, one register per cycle, for the testbench and checker.

## Interface

Parameters:
- WORD, 32, datapath width (matches the shared `WORD` constant).
- NREGS, 32, number of architectural registers; address width is 5.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- wb_in  in  1  write-back enable from MEM/WB.
- mem_r_in  in  1  selects mem_result_in (1) or alu_result_in (0).
- mem_result_in  in  WORD  load data.
- alu_result_in  in  WORD  ALU data.
- reg_dest_in  in  5  destination register.
- terminate_in  in  1  terminate marker of the retiring instruction.
- rs_addr, rt_addr  in  5  ID read addresses.
- rs_data, rt_data  out  WORD  ID read data (combinational).
- fwd_valid  out  1  WB forwarding valid (combinational).
- fwd_dest  out  5  WB forwarding destination.
- fwd_data  out  WORD  WB forwarding data.
- wb_count  out  32  number of committed writes.
- halted  out  1  high once terminate has been accepted.
- dump_valid  out  1  dump beat valid.
- dump_addr  out  5  register index of the dump beat.
- dump_data  out  WORD  register value of the dump beat.
- done  out  1  dump complete (sticky until reset).

## Operation

- wdata = mem_r_in ? mem_result_in : alu_result_in.
- we = wb_in && reg_dest_in != 0 && state == RUN.
- Register 0 is never written and always reads 0.
- Read ports:
  - addr 0 returns 0.
  - When we is high and addr == reg_dest_in, the port returns wdata (bypass).
  - Otherwise the port returns the array value.
- Forwarding tap:
  - fwd_valid = we.
  - fwd_dest = reg_dest_in.
  - fwd_data = wdata.
  - In non-RUN states all three are 0.
- wb_count increments by 1 on every edge in RUN with wb_in == 1, including writes to register 0. It wraps modulo 2^32.
- FSM states: RUN, DUMP, DONE.
  - RUN → DUMP when terminate_in == 1. The terminating instruction's own write (if any) still commits on that edge, and idx is set to 0.
  - DUMP: on each edge, dump_valid <= 1, dump_addr <= idx, dump_data <= regs[idx], and idx increments. On the edge with idx == 31, the state moves to DONE.
  - DONE: dump_valid <= 0 and done <= 1. The block stays in DONE until reset.
- In DUMP and DONE, all MEM/WB inputs are ignored: no writes and no counting.
- halted = (state != RUN). It is registered by virtue of the state register.
- Reset clears:
  - all registers and wb_count to 0;
  - state to RUN and idx to 0;
  - dump_valid, dump_addr, dump_data, done and halted to 0.
- Reset mid-DUMP aborts the dump immediately; no further beats are produced.

## Timing

- Writes are committed on the rising edge. Same-cycle readers see the value through the bypass; from the next cycle they see it from the array.
- Read and forwarding latency: 0 cycles (combinational).
- Let terminate_in be sampled at edge T0:
  - halted is 1 after T0.
  - Dump beat k (k = 0..31) is visible after edge T0+1+k.
  - done is 1 and dump_valid is 0 after edge T0+33.
- There is no handshake back-pressure: the dump consumer must accept one beat per cycle.
- Terminate and a write in the same cycle: the write commits, and the dump reflects it.

## Structure

- Shared constants package (constants.v) holds:
  - WORD and REG_ADDR_W = 5;
  - NREGS;
  - FSM encodings WBC_RUN, WBC_DUMP, WBC_DONE.
- Sub-module regfile_2r1w:
  - array with 2 combinational read ports and 1 synchronous write port;
  - zero-register rule and write bypass;
  - a third read port for the dump.
- The top level contains the write-data mux, forwarding tap, counter and FSM.

## Test plan

- Write then read: wb_in=1, mem_r_in=0, alu_result_in=0x12345678, reg_dest_in=5. The next cycle, rs_addr=5 → rs_data=0x12345678, and wb_count=1.
- Register zero: wb_in=1, reg_dest_in=0, data=0xFFFFFFFF → rs_addr=0 reads 0, fwd_valid=0, and wb_count still increments.
- Bypass and mux select: wb_in=1, mem_r_in=1, mem_result_in=0xA5A5A5A5, alu_result_in=0x1, reg_dest_in=7, rt_addr=7 in the same cycle → rt_data=0xA5A5A5A5, fwd_valid=1, fwd_dest=7, fwd_data=0xA5A5A5A5.
- Terminate and dump:
  - Stimulus: preload r1..r31 = index*3, then pulse terminate_in together with a write of r31=0xDEAD.
  - Expected: 32 consecutive dump beats with addresses 0..31, r0=0 and r31=0xDEAD; then done=1 and dump_valid=0.
- Inputs ignored after halt: with wb_in=1 writing r2=0x99 during DUMP → neither the dump value nor a post-DONE read of r2 changes, and wb_count is unchanged.
- Reset mid-dump: assert rst at dump beat 10 → the next cycle shows dump_valid=0, halted=0, done=0, all reads 0 and wb_count=0. Normal commits then resume.

Source files
------------

// File: rtl/wb_commit_unit_pkg.sv
// Shared constants and FSM encoding for the write-back commit stage.
package wb_commit_unit_pkg;

  localparam int WORD       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NREGS      = 32;

  typedef enum logic [1:0] {
    WBC_RUN  = 2'd0,
    WBC_DUMP = 2'd1,
    WBC_DONE = 2'd2
  } wbc_state_t;

endpackage

// File: rtl/wb_commit_unit_if.sv
// MEM/WB input, ID read, forwarding and dump signals of the commit stage.
interface wb_commit_unit_if;
  import wb_commit_unit_pkg::*;

  logic                  wb_in;
  logic                  mem_r_in;
  logic [WORD-1:0]       mem_result_in;
  logic [WORD-1:0]       alu_result_in;
  logic [REG_ADDR_W-1:0] reg_dest_in;
  logic                  terminate_in;
  logic [REG_ADDR_W-1:0] rs_addr;
  logic [REG_ADDR_W-1:0] rt_addr;
  logic [WORD-1:0]       rs_data;
  logic [WORD-1:0]       rt_data;
  logic                  fwd_valid;
  logic [REG_ADDR_W-1:0] fwd_dest;
  logic [WORD-1:0]       fwd_data;
  logic [31:0]           wb_count;
  logic                  halted;
  logic                  dump_valid;
  logic [REG_ADDR_W-1:0] dump_addr;
  logic [WORD-1:0]       dump_data;
  logic                  done;

  modport master (
    output wb_in, mem_r_in, mem_result_in, alu_result_in, reg_dest_in,
           terminate_in, rs_addr, rt_addr,
    input  rs_data, rt_data, fwd_valid, fwd_dest, fwd_data, wb_count,
           halted, dump_valid, dump_addr, dump_data, done
  );

  modport slave (
    input  wb_in, mem_r_in, mem_result_in, alu_result_in, reg_dest_in,
           terminate_in, rs_addr, rt_addr,
    output rs_data, rt_data, fwd_valid, fwd_dest, fwd_data, wb_count,
           halted, dump_valid, dump_addr, dump_data, done
  );

endinterface

// File: rtl/wb_commit_unit_regfile.sv
// 32-entry register file: two bypassed ID read ports, one write port and
// a raw dump read port. Register 0 is hardwired to zero.
module regfile_2r1w
  import wb_commit_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [WORD-1:0]       wdata,
  input  logic [REG_ADDR_W-1:0] ra_addr,
  output logic [WORD-1:0]       ra_data,
  input  logic [REG_ADDR_W-1:0] rb_addr,
  output logic [WORD-1:0]       rb_data,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  output logic [WORD-1:0]       rd_data
);

  logic [WORD-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  // Same-cycle bypass lets ID see the value being committed this edge.
  always_comb begin
    ra_data = regs[ra_addr];
    if (ra_addr == '0)                ra_data = '0;
    else if (we && ra_addr == waddr)  ra_data = wdata;
  end

  always_comb begin
    rb_data = regs[rb_addr];
    if (rb_addr == '0)                rb_data = '0;
    else if (we && rb_addr == waddr)  rb_data = wdata;
  end

  assign rd_data = regs[rd_addr];

endmodule

// File: rtl/wb_commit_unit.sv
// Write-back commit stage: data select, forwarding tap, commit counter and
// the terminate/dump sequencer.
//   state    | meaning
//   WBC_RUN  | committing MEM/WB writes
//   WBC_DUMP | streaming regs[idx], one per cycle
//   WBC_DONE | dump finished, inputs ignored until reset
module wb_commit_unit
  import wb_commit_unit_pkg::*;
(
  input logic            clk,
  input logic            rst,
  wb_commit_unit_if.slave bus
);

  wbc_state_t            state, state_next;
  logic [REG_ADDR_W-1:0] idx;
  logic [WORD-1:0]       wdata, dump_rd, rs_data, rt_data;
  logic [WORD-1:0]       dump_data;
  logic [REG_ADDR_W-1:0] dump_addr;
  logic [31:0]           wb_count;
  logic                  dump_valid, done, run, we;

  assign run   = (state == WBC_RUN);
  assign wdata = bus.mem_r_in ? bus.mem_result_in : bus.alu_result_in;
  assign we    = bus.wb_in && (bus.reg_dest_in != '0) && run;

  regfile_2r1w u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .waddr   (bus.reg_dest_in),
    .wdata   (wdata),
    .ra_addr (bus.rs_addr),
    .ra_data (rs_data),
    .rb_addr (bus.rt_addr),
    .rb_data (rt_data),
    .rd_addr (idx),
    .rd_data (dump_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= WBC_RUN;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      WBC_RUN:  if (bus.terminate_in) state_next = WBC_DUMP;
      WBC_DUMP: if (idx == REG_ADDR_W'(NREGS - 1)) state_next = WBC_DONE;
      WBC_DONE: state_next = WBC_DONE;
      default:  state_next = WBC_RUN;
    endcase
  end

  always_comb begin
    bus.halted    = !run;
    bus.fwd_valid = we;
    bus.fwd_dest  = run ? bus.reg_dest_in : '0;
    bus.fwd_data  = run ? wdata : '0;
  end

  // Counting includes writes aimed at r0; only the commit itself is suppressed.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_count   <= '0;
      idx        <= '0;
      dump_valid <= 1'b0;
      dump_addr  <= '0;
      dump_data  <= '0;
      done       <= 1'b0;
    end else begin
      if (run && bus.wb_in) wb_count <= wb_count + 32'd1;
      case (state)
        WBC_RUN: if (bus.terminate_in) idx <= '0;
        WBC_DUMP: begin
          dump_valid <= 1'b1;
          dump_addr  <= idx;
          dump_data  <= dump_rd;
          idx        <= idx + 1'b1;
        end
        WBC_DONE: begin
          dump_valid <= 1'b0;
          done       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.rs_data    = rs_data;
  assign bus.rt_data    = rt_data;
  assign bus.wb_count   = wb_count;
  assign bus.dump_valid = dump_valid;
  assign bus.dump_addr  = dump_addr;
  assign bus.dump_data  = dump_data;
  assign bus.done       = done;

endmodule
